// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
// Imported by the grant logic and the arbiter top.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    localparam int MEM_LAT_DEF  = 2;
    localparam int MAX_LOCK_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Combinational winner selection between CPU and DMA requesters.
// Locked DMA bursts are capped so the CPU always gets a turn.
module arb_grant_logic
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic       cpu_req,
    input  logic       dma_req,
    input  logic       dma_lock,
    input  logic       last_dma,
    input  logic [3:0] lock_cnt,
    output logic       grant_cpu,
    output logic       grant_dma,
    output logic       lock_inc
);

    localparam logic [3:0] LOCK_MAX = 4'(MAX_LOCK);

    logic both;
    logic full;

    assign both = cpu_req & dma_req;
    assign full = (lock_cnt >= LOCK_MAX);

    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        lock_inc  = 1'b0;
        unique case (1'b1)
            (cpu_req & ~dma_req): grant_cpu = 1'b1;
            (dma_req & ~cpu_req): grant_dma = 1'b1;
            (both & full):        grant_cpu = 1'b1;
            (both & ~full & dma_lock): begin
                grant_dma = 1'b1;
                lock_inc  = 1'b1;
            end
            (both & ~full & ~dma_lock): begin
                grant_cpu = last_dma;
                grant_dma = ~last_dma;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between CPU and DMA with an
// issue / latency-wait / acknowledge sequence per access.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = MEM_LAT_DEF,
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    input  logic              dma_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam logic [2:0] WAIT_LD =
        (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;

    state_t            state;
    logic              last_dma;
    logic [3:0]        lock_cnt;
    logic [2:0]        lat_cnt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;
    logic              grant_cpu;
    logic              grant_dma;
    logic              lock_inc;
    logic              rd_done;

    arb_grant_logic #(
        .MAX_LOCK (MAX_LOCK)
    ) u_grant (
        .cpu_req   (cpu_req),
        .dma_req   (dma_req),
        .dma_lock  (dma_lock),
        .last_dma  (last_dma),
        .lock_cnt  (lock_cnt),
        .grant_cpu (grant_cpu),
        .grant_dma (grant_dma),
        .lock_inc  (lock_inc)
    );

    // Read data bypasses the holding register in the ack cycle.
    assign rd_done   = (state == DONE) & ~mem_we;
    assign cpu_rdata = (rd_done && owner == OWN_CPU) ? mem_rdata : cpu_rdata_q;
    assign dma_rdata = (rd_done && owner == OWN_DMA) ? mem_rdata : dma_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_dma    <= 1'b1;
            lock_cnt    <= '0;
            lat_cnt     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            owner       <= OWN_NONE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_cpu | grant_dma) begin
                        state     <= ISSUE;
                        mem_en    <= 1'b1;
                        last_dma  <= grant_dma;
                        owner     <= grant_cpu ? OWN_CPU : OWN_DMA;
                        mem_we    <= grant_cpu ? cpu_we : dma_we;
                        mem_addr  <= grant_cpu ? cpu_addr : dma_addr;
                        mem_wdata <= grant_cpu ? cpu_wdata : dma_wdata;
                        if (grant_cpu)
                            lock_cnt <= '0;
                        else if (lock_inc)
                            lock_cnt <= lock_cnt + 4'd1;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    lat_cnt <= WAIT_LD;
                    if (MEM_LAT == 1) begin
                        state   <= DONE;
                        cpu_ack <= (owner == OWN_CPU);
                        dma_ack <= (owner == OWN_DMA);
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        state   <= DONE;
                        cpu_ack <= (owner == OWN_CPU);
                        dma_ack <= (owner == OWN_DMA);
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    owner   <= OWN_NONE;
                    if (!mem_we && owner == OWN_CPU)
                        cpu_rdata_q <= mem_rdata;
                    if (!mem_we && owner == OWN_DMA)
                        dma_rdata_q <= mem_rdata;
                end
                default: state <= IDLE;
            endcase
            if (!dma_lock)
                lock_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level model, directed pins, random traffic.
// A toy memory answers exactly MEM_LAT cycles after each strobe.
module tb_mem_port_arbiter;

    localparam int MEM_LAT  = 2;
    localparam int MAX_LOCK = 4;
    localparam int DONE_PH  = 1 + MEM_LAT;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, cpu_stall, dma_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .MAX_LOCK(MAX_LOCK)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .dma_lock(dma_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner)
    );

    function automatic logic [31:0] init_val(int i);
        if (i == 16) return 32'hDEADBEEF;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    // Toy memory: data valid only in the cycle MEM_LAT after mem_en.
    logic [31:0] wr_data [256];
    logic [255:0] wr_mask = '0;
    logic [31:0] rd_val = '0;
    int          rd_cnt = 0;

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wr_data[mem_addr[9:2]] <= mem_wdata;
            wr_mask[mem_addr[9:2]] <= 1'b1;
        end
        if (mem_en) begin
            rd_val <= wr_mask[mem_addr[9:2]] ? wr_data[mem_addr[9:2]]
                                             : init_val(int'(mem_addr[9:2]));
            rd_cnt <= MEM_LAT;
        end else if (rd_cnt != 0) begin
            rd_cnt <= rd_cnt - 1;
        end
    end

    assign mem_rdata = (rd_cnt == 1) ? rd_val : 32'hA5A55A5A;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit rand_mode = 0;

    logic        d_rst, d_creq, d_cwe, d_dreq, d_dwe, d_lock;
    logic [31:0] d_caddr, d_cwd, d_daddr, d_dwd;

    // Model: phase counts cycles since grant (0 = no access in flight).
    int          m_phase;
    logic [1:0]  m_win, m_last;
    int          m_lock;
    logic        m_we;
    logic [31:0] m_addr, m_wdata, m_chold, m_dhold;
    logic [31:0] ref_mem [256];
    logic        e_cack, e_dack;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_win = 2'd0; m_last = 2'd2; m_lock = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_chold = '0; m_dhold = '0;
    endtask

    task automatic compare();
        logic [31:0] e_crd, e_drd;
        e_cack = (m_phase == DONE_PH) && (m_win == 2'd1);
        e_dack = (m_phase == DONE_PH) && (m_win == 2'd2);
        e_crd = (e_cack && !m_we) ? ref_mem[m_addr[9:2]] : m_chold;
        e_drd = (e_dack && !m_we) ? ref_mem[m_addr[9:2]] : m_dhold;
        chk("owner", 32'(owner), 32'(m_win));
        chk("mem_en", 32'(mem_en), 32'(m_phase == 1));
        chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
        chk("dma_ack", 32'(dma_ack), 32'(e_dack));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cack));
        chk("cpu_rdata", cpu_rdata, e_crd);
        chk("dma_rdata", dma_rdata, e_drd);
        chk("mem_we", 32'(mem_we), 32'(m_we));
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
    endtask

    task automatic advance();
        logic [1:0] g;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            g = 2'd0;
            if (cpu_req && !dma_req)       g = 2'd1;
            else if (dma_req && !cpu_req)  g = 2'd2;
            else if (cpu_req && dma_req) begin
                if (m_lock >= MAX_LOCK)    g = 2'd1;
                else if (dma_lock) begin
                    g = 2'd2;
                    m_lock++;
                end else begin
                    g = (m_last == 2'd1) ? 2'd2 : 2'd1;
                end
            end
            if (g == 2'd1) m_lock = 0;
            if (g != 2'd0) begin
                m_win = g; m_last = g; m_phase = 1;
                m_we    = (g == 2'd1) ? cpu_we : dma_we;
                m_addr  = (g == 2'd1) ? cpu_addr : dma_addr;
                m_wdata = (g == 2'd1) ? cpu_wdata : dma_wdata;
            end
        end else if (m_phase == DONE_PH) begin
            if (!m_we && m_win == 2'd1) m_chold = ref_mem[m_addr[9:2]];
            if (!m_we && m_win == 2'd2) m_dhold = ref_mem[m_addr[9:2]];
            m_phase = 0;
            m_win = 2'd0;
        end else begin
            if (m_phase == 1 && m_we) ref_mem[m_addr[9:2]] = m_wdata;
            m_phase++;
        end
        if (!dma_lock) m_lock = 0;
    endtask

    task automatic choose();
        bit infl_c, infl_d;
        infl_c = (m_phase != 0) && (m_win == 2'd1);
        infl_d = (m_phase != 0) && (m_win == 2'd2);
        if (e_cack || (!d_creq && !infl_c)) begin
            d_creq  = ($urandom_range(99) < 40);
            d_cwe   = 1'($urandom_range(1));
            d_caddr = 32'($urandom_range(255)) << 2;
            d_cwd   = $urandom;
        end else if (d_creq && infl_c && $urandom_range(99) < 4) begin
            d_creq = 1'b0;
        end
        if (e_dack || (!d_dreq && !infl_d)) begin
            d_dreq  = ($urandom_range(99) < 40);
            d_dwe   = 1'($urandom_range(1));
            d_daddr = 32'($urandom_range(255)) << 2;
            d_dwd   = $urandom;
        end else if (d_dreq && infl_d && $urandom_range(99) < 4) begin
            d_dreq = 1'b0;
        end
        if ($urandom_range(15) == 0) d_lock = ~d_lock;
        d_rst = ($urandom_range(199) == 0);
    endtask

    task automatic drive();
        reset = d_rst;
        cpu_req = d_creq; cpu_we = d_cwe; cpu_addr = d_caddr; cpu_wdata = d_cwd;
        dma_req = d_dreq; dma_we = d_dwe; dma_addr = d_daddr; dma_wdata = d_dwd;
        dma_lock = d_lock;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare();
        if (rand_mode) choose();
        drive();
        advance();
    endtask

    task automatic idle_inputs();
        d_creq = 0; d_cwe = 0; d_caddr = '0; d_cwd = '0;
        d_dreq = 0; d_dwe = 0; d_daddr = '0; d_dwd = '0;
        d_lock = 0;
    endtask

    logic [1:0] grants [$];
    logic [1:0] exp_g [9];

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        exp_g = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
        idle_inputs();
        d_rst = 1'b1;
        drive();
        model_reset();
        tick();
        tick();
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dma_rdata", dma_rdata, 32'd0);
        d_rst = 1'b0;
        tick();

        // Single CPU read of 0x40.
        d_creq = 1; d_cwe = 0; d_caddr = 32'h40;
        tick();
        tick();
        chk("rd_issue_en", 32'(mem_en), 32'd1);
        chk("rd_issue_owner", 32'(owner), 32'd1);
        chk("rd_issue_addr", mem_addr, 32'h40);
        tick();
        chk("rd_wait_en", 32'(mem_en), 32'd0);
        chk("rd_wait_ack", 32'(cpu_ack), 32'd0);
        d_creq = 0;
        tick();
        chk("rd_done_ack", 32'(cpu_ack), 32'd1);
        chk("rd_done_data", cpu_rdata, 32'hDEADBEEF);
        tick();
        chk("rd_after_ack", 32'(cpu_ack), 32'd0);
        chk("rd_after_owner", 32'(owner), 32'd0);
        chk("rd_hold_data", cpu_rdata, 32'hDEADBEEF);

        // Locked DMA burst, then plain round-robin.
        d_creq = 1; d_caddr = 32'h80; d_dreq = 1; d_daddr = 32'hC0; d_lock = 1;
        for (int i = 0; i < 80 && grants.size() < 9; i++) begin
            tick();
            if (mem_en) begin
                grants.push_back(owner);
                if (grants.size() == 6) d_lock = 0;
            end
        end
        chk("grant_count", 32'(grants.size()), 32'd9);
        for (int i = 0; i < 9 && i < grants.size(); i++)
            chk($sformatf("grant_%0d", i), 32'(grants[i]), 32'(exp_g[i]));
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();

        // DMA write then CPU read of the same word.
        d_rst = 1; tick();
        d_rst = 0; tick();
        d_dreq = 1; d_dwe = 1; d_daddr = 32'h100; d_dwd = 32'h12345678;
        tick();
        tick();
        chk("dw_en", 32'(mem_en), 32'd1);
        chk("dw_we", 32'(mem_we), 32'd1);
        chk("dw_addr", mem_addr, 32'h100);
        chk("dw_wdata", mem_wdata, 32'h12345678);
        tick();
        d_dreq = 0; d_creq = 1; d_cwe = 0; d_caddr = 32'h100;
        tick();
        chk("dw_ack", 32'(dma_ack), 32'd1);
        tick();
        tick();
        tick();
        d_creq = 0;
        tick();
        chk("cr_ack", 32'(cpu_ack), 32'd1);
        chk("cr_data", cpu_rdata, 32'h12345678);
        chk("cr_dma_rdata", dma_rdata, 32'd0);
        tick();

        // Reset while a CPU read sits in WAIT.
        d_creq = 1; d_cwe = 0; d_caddr = 32'h40;
        tick();
        tick();
        chk("rw_issue_en", 32'(mem_en), 32'd1);
        d_rst = 1;
        tick();
        d_rst = 0;
        tick();
        chk("rw_owner", 32'(owner), 32'd0);
        chk("rw_mem_en", 32'(mem_en), 32'd0);
        chk("rw_ack", 32'(cpu_ack), 32'd0);
        chk("rw_rdata", cpu_rdata, 32'd0);
        tick();
        chk("rw_regrant_en", 32'(mem_en), 32'd1);
        chk("rw_regrant_owner", 32'(owner), 32'd1);
        tick();
        d_creq = 0;
        tick();
        chk("rw_regrant_ack", 32'(cpu_ack), 32'd1);
        chk("rw_regrant_data", cpu_rdata, 32'hDEADBEEF);
        tick();

        // Randomized traffic against the model.
        idle_inputs();
        rand_mode = 1;
        for (int i = 0; i < 3000; i++) tick();
        rand_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the CPU datapath (instruction fetch and load/store) and a DMA/boot-loader requester.
- Sequences each access through issue, latency-wait and acknowledge phases, and stalls the CPU while its access is pending.
- Supports locked DMA bursts with a bounded length, so neither side can starve the other.
- Sits between the CPU top level, the DMA engine and the memory block.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, cycles from mem_en assertion to valid mem_rdata; legal range 1..7.
- MAX_LOCK, 4, maximum consecutive DMA grants under dma_lock while the CPU is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held high with stable address and data until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ack; combinational.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack  as the cpu_* ports, for the DMA side.
- dma_lock  in  1  requests consecutive DMA grants (burst).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; valid only with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- owner  out  2  00 = none, 01 = CPU, 10 = DMA; the current grant holder.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state IDLE; every output 0, including cpu_rdata and dma_rdata; last_owner = DMA, so the CPU wins the first tie; lock_cnt = 0.
- State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
  - WAIT lasts MEM_LAT-1 cycles and is skipped when MEM_LAT = 1.
- IDLE:
  - Samples the requests.
  - On a grant, latches we/addr/wdata of the winner into internal registers, sets owner, and goes to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1.
  - mem_we, mem_addr and mem_wdata are driven from the latched registers.
- WAIT: mem_en = 0; a latency counter counts down.
- DONE (1 cycle):
  - The winner's ack = 1.
  - For a read, the winner's rdata is driven by mem_rdata (bypass) and the holding register captures it. rdata then holds until the next read by that requester completes.
  - Write completions leave rdata unchanged.
- Latency: a request first seen in IDLE at cycle t produces mem_en at t+1 and ack at t+1+MEM_LAT. The next grant is possible at t+2+MEM_LAT.
- Requester rule: a requester deasserts req in the cycle after its ack. A req still high in IDLE starts a new access.
- Arbitration in IDLE:
  - Only one requester active: it wins.
  - Both active, dma_lock = 1, lock_cnt < MAX_LOCK: DMA wins and lock_cnt increments.
  - Both active, lock_cnt == MAX_LOCK: CPU wins and lock_cnt clears.
  - Both active, no lock: round-robin; the requester that is not last_owner wins.
  - last_owner updates on every grant.
- lock_cnt clears whenever dma_lock = 0 or the CPU is granted. DMA grants with the CPU idle do not increment lock_cnt.
- Outside ISSUE, mem_we, mem_addr and mem_wdata hold their last values; only mem_en qualifies them.
- Req dropped mid-transaction: the access completes and ack still pulses; the memory write is not cancelled.
- Reset mid-transaction: immediate return to reset values; the in-flight ack is never issued.
- owner returns to 00 in the IDLE cycle after DONE.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3);
  - owner codes (OWN_NONE, OWN_CPU, OWN_DMA);
  - MEM_LAT and MAX_LOCK defaults.
- Natural sub-module: arb_grant_logic — combinational winner selection from cpu_req, dma_req, dma_lock, last_owner and lock_cnt. The FSM, counters and data registers stay in the top module.

Test Plan:
- Single CPU read: cpu_req=1, we=0, addr=0x40, mem returns 0xDEADBEEF, MEM_LAT=2, request seen at cycle t -> mem_en at t+1 only; cpu_ack at t+3; cpu_rdata=0xDEADBEEF from t+3 onward; cpu_stall high t..t+2.
- Simultaneous CPU+DMA reads, no lock, held continuously -> grants alternate CPU, DMA, CPU; owner sequence 01, 10, 01; each ack 4 cycles apart (MEM_LAT=2).
- DMA lock burst: dma_lock=1, both requesting, MAX_LOCK=4 -> 4 DMA grants, then 1 CPU grant, then DMA resumes; lock_cnt returns to 0 after the CPU grant.
- DMA write 0x12345678 to 0x100, then CPU read of 0x100 -> mem_we=1 with mem_addr=0x100 in the DMA ISSUE cycle; CPU read ack returns 0x12345678; dma_rdata unchanged.
- Reset asserted in the WAIT cycle of a CPU read -> next cycle owner=00, mem_en=0, cpu_ack never pulses, cpu_rdata=0; a re-asserted cpu_req is granted normally.
- MEM_LAT=1 build: CPU write seen at t -> mem_en at t+1, cpu_ack at t+2, next grant possible at t+3.
